// File: rtl/led_pattern_gen_pkg.sv
// Shared types for the multi-channel LED pattern generator.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PWM   = 2'd3
   } led_mode_e;

   // Blink toggles when the counter reaches this value; period 0 acts as 1.
   function automatic logic [31:0] blink_last(input logic [31:0] period);
      return (period == 32'd0) ? 32'd0 : period - 32'd1;
   endfunction

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// Tick prescaler: one-clock tick every CLK_HZ/TICK_HZ cycles.
module led_prescaler #(
   parameter int CLK_HZ  = 12000000,
   parameter int TICK_HZ = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic sync,
   output logic tick
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("led_prescaler: CLK_HZ/TICK_HZ must be at least 2");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      if (sync) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM on a shared tick.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int CLK_HZ         = 12000000,
   parameter int TICK_HZ        = 1000,
   parameter int CHANNELS       = 5,
   parameter int PERIOD_W       = 16,
   parameter int DUTY_W         = 8,
   parameter int DEFAULT_PERIOD = 500,
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [DUTY_W-1:0]   cfg_duty,
   input  logic                sync,
   output logic [CHANNELS-1:0] led,
   output logic                tick
);

   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_ch
      $error("led_pattern_gen: CHANNELS must be 1..32");
   end

   logic              tick_w;
   logic [DUTY_W-1:0] phase_q, phase_d;

   led_prescaler #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .sync  (sync),
      .tick  (tick_w)
   );

   assign tick = tick_w;

   always_comb begin
      phase_d = phase_q + DUTY_W'(1);
      if (sync) phase_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) phase_q <= '0;
      else       phase_q <= phase_d;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam bit IS_TOP = (i == CHANNELS - 1);
      localparam led_mode_e RST_MODE =
         IS_TOP ? LED_BLINK : LED_OFF;
      localparam logic [PERIOD_W-1:0] RST_PERIOD =
         IS_TOP ? PERIOD_W'(DEFAULT_PERIOD) : '0;

      led_mode_e           mode_q, mode_d, wr_mode;
      logic [PERIOD_W-1:0] period_q, period_d;
      logic [PERIOD_W-1:0] cnt_q, cnt_d, last;
      logic [DUTY_W-1:0]   duty_q, duty_d;
      logic                led_q, led_d, hit;

      assign hit     = cfg_we && (cfg_ch == CH_W'(i));
      assign wr_mode = led_mode_e'(cfg_mode);
      assign last    = PERIOD_W'(blink_last(32'(period_q)));

      always_comb begin
         mode_d   = mode_q;
         period_d = period_q;
         duty_d   = duty_q;
         cnt_d    = cnt_q;
         led_d    = led_q;
         if (hit) begin
            // A write always restarts the channel, even with unchanged values.
            mode_d   = wr_mode;
            period_d = cfg_period;
            duty_d   = cfg_duty;
            cnt_d    = '0;
            unique case (wr_mode)
               LED_OFF:   led_d = 1'b0;
               LED_ON:    led_d = 1'b1;
               LED_BLINK: led_d = 1'b1;
               LED_PWM:   led_d = phase_q < cfg_duty;
            endcase
         end else begin
            if (sync) cnt_d = '0;
            unique case (mode_q)
               LED_OFF: led_d = 1'b0;
               LED_ON:  led_d = 1'b1;
               LED_BLINK: begin
                  if (sync) begin
                     led_d = 1'b1;
                  end else if (tick_w) begin
                     if (cnt_q == last) begin
                        led_d = ~led_q;
                        cnt_d = '0;
                     end else begin
                        cnt_d = cnt_q + PERIOD_W'(1);
                     end
                  end
               end
               LED_PWM: led_d = phase_q < duty_q;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            mode_q   <= RST_MODE;
            period_q <= RST_PERIOD;
            duty_q   <= '0;
            cnt_q    <= '0;
            led_q    <= 1'b0;
         end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
         end
      end

      assign led[i] = led_q;
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed scoreboard bench for led_pattern_gen (DIV=10, 4 channels).
module tb_led_pattern_gen;

   localparam int PW = 16;
   localparam int DW = 4;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   jc = 0;
   int   ones;

   logic          clk;
   logic          reset;
   logic          cfg_we;
   logic          we3;
   logic [1:0]    cfg_ch;
   logic [1:0]    cfg_mode;
   logic [PW-1:0] cfg_period;
   logic [DW-1:0] cfg_duty;
   logic          sync;
   logic [3:0]    led;
   logic          tick;
   logic [2:0]    led3;
   logic          tick3;

   led_pattern_gen #(
      .CLK_HZ(100), .TICK_HZ(10), .CHANNELS(4),
      .PERIOD_W(PW), .DUTY_W(DW), .DEFAULT_PERIOD(3)
   ) u_dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_period(cfg_period), .cfg_duty(cfg_duty),
      .sync(sync), .led(led), .tick(tick)
   );

   // Three channels so that cfg_ch=3 is a real out-of-range index.
   led_pattern_gen #(
      .CLK_HZ(100), .TICK_HZ(10), .CHANNELS(3),
      .PERIOD_W(PW), .DUTY_W(DW), .DEFAULT_PERIOD(3)
   ) u_dut3 (
      .clk(clk), .reset(reset), .cfg_we(we3),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_period(cfg_period), .cfg_duty(cfg_duty),
      .sync(sync), .led(led3), .tick(tick3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at(input int t);
      step(t - jc);
      jc = t;
   endtask

   task automatic expect_v(input string tag, input int v);
      exp_t e;
      e.tag = tag;
      e.exp = 8'(v);
      sb.push_back(e);
   endtask

   task automatic check_v(input logic [7:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%0h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic idle();
      cfg_we = 1'b0;
      we3    = 1'b0;
      sync   = 1'b0;
   endtask

   task automatic wr(input int ch, input int mode,
                     input int per, input int duty);
      cfg_ch     = 2'(ch);
      cfg_mode   = 2'(mode);
      cfg_period = PW'(per);
      cfg_duty   = DW'(duty);
      cfg_we     = 1'b1;
   endtask

   // Apply the driven inputs on one edge and restart the local time base.
   task automatic apply();
      step(1);
      idle();
      jc = 0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      cfg_ch = '0;
      cfg_mode = '0;
      cfg_period = '0;
      cfg_duty = '0;

      // reset state
      expect_v("rst_led", 0);
      expect_v("rst_tick", 0);
      expect_v("rst_led3", 0);
      expect_v("rst_tick3", 0);
      step(2);
      check_v(8'(led));
      check_v(8'(tick));
      check_v(8'(led3));
      check_v(8'(tick3));

      // power-up: tick every 10 clks, top LED on 3rd..6th tick
      reset = 1'b0;
      for (int k = 1; k <= 61; k++) begin
         expect_v($sformatf("pu_tick_k%0d", k), int'(k % 10 == 0));
         expect_v($sformatf("pu_led3_k%0d", k), int'(k >= 31 && k <= 60));
         step(1);
         check_v(8'(tick));
         check_v(8'(led[3]));
      end
      expect_v("pu_led_low", 0);
      check_v(8'(led[2:0]));

      // ch0 BLINK period 2 together with sync
      sync = 1'b1;
      wr(0, 2, 2, 0);
      apply();
      expect_v("b2_led0_j0", 1);
      expect_v("b2_led3_j0", 1);
      check_v(8'(led[0]));
      check_v(8'(led[3]));
      expect_v("b2_tick_j9", 0);  at(9);  check_v(8'(tick));
      expect_v("b2_tick_j10", 1); at(10); check_v(8'(tick));
      expect_v("b2_led0_j20", 1); at(20); check_v(8'(led[0]));
      expect_v("b2_led0_j21", 0); at(21); check_v(8'(led[0]));
      expect_v("b2_led3_j30", 1); at(30); check_v(8'(led[3]));
      expect_v("b2_led3_j31", 0); at(31); check_v(8'(led[3]));
      expect_v("b2_led0_j40", 0); at(40); check_v(8'(led[0]));
      expect_v("b2_led0_j41", 1); at(41); check_v(8'(led[0]));

      // ch0 BLINK period 0 toggles every tick
      sync = 1'b1;
      wr(0, 2, 0, 0);
      apply();
      expect_v("b0_led0_j0", 1);  check_v(8'(led[0]));
      expect_v("b0_led0_j10", 1); at(10); check_v(8'(led[0]));
      expect_v("b0_led0_j11", 0); at(11); check_v(8'(led[0]));
      expect_v("b0_led0_j20", 0); at(20); check_v(8'(led[0]));
      expect_v("b0_led0_j21", 1); at(21); check_v(8'(led[0]));

      // ch1 PWM duty 4: high 4 of 16 clks
      sync = 1'b1;
      wr(1, 3, 0, 4);
      apply();
      ones = 0;
      for (int m = 1; m <= 32; m++) begin
         expect_v($sformatf("pwm4_m%0d", m), int'((m - 1) % 16 < 4));
         step(1);
         check_v(8'(led[1]));
         if (m > 16) ones += int'(led[1]);
      end
      expect_v("pwm4_count", 4);
      check_v(8'(ones));

      // ch1 PWM duty 0: always low
      sync = 1'b1;
      wr(1, 3, 0, 0);
      apply();
      expect_v("pwm0_m0", 0);
      check_v(8'(led[1]));
      for (int m = 1; m <= 16; m++) begin
         expect_v($sformatf("pwm0_m%0d", m), 0);
         step(1);
         check_v(8'(led[1]));
      end

      // ch1 PWM duty 15: low 1 clk per 16
      sync = 1'b1;
      wr(1, 3, 0, 15);
      apply();
      for (int m = 1; m <= 32; m++) begin
         expect_v($sformatf("pwm15_m%0d", m), int'((m - 1) % 16 != 15));
         step(1);
         check_v(8'(led[1]));
      end

      // out-of-range index on the 3-channel instance is ignored
      sync = 1'b1;
      we3  = 1'b1;
      cfg_ch = 2'd3;
      cfg_mode = 2'd0;
      apply();
      expect_v("oor_led3", 4);
      expect_v("oor_main_led0", 1);
      expect_v("oor_main_led2", 0);
      expect_v("oor_main_led3", 1);
      check_v(8'(led3));
      check_v(8'(led[0]));
      check_v(8'(led[2]));
      check_v(8'(led[3]));

      // ch2 ON then OFF
      wr(2, 1, 0, 0);
      apply();
      expect_v("on_led2", 1);
      check_v(8'(led[2]));
      wr(2, 0, 0, 0);
      apply();
      expect_v("off_led2", 0);
      check_v(8'(led[2]));

      // sync on a tick cycle with a write to ch0 BLINK period 1
      sync = 1'b1;
      apply();
      expect_v("st_tick_j10", 1); at(10); check_v(8'(tick));
      sync = 1'b1;
      wr(0, 2, 1, 0);
      apply();
      expect_v("st_tick_j0", 0);
      expect_v("st_led0_j0", 1);
      expect_v("st_led3_j0", 1);
      check_v(8'(tick));
      check_v(8'(led[0]));
      check_v(8'(led[3]));
      expect_v("st_tick_j9", 0);  at(9);  check_v(8'(tick));
      expect_v("st_tick_j10", 1); at(10); check_v(8'(tick));
      expect_v("st_led0_j10", 1); check_v(8'(led[0]));
      expect_v("st_led0_j11", 0); at(11); check_v(8'(led[0]));
      expect_v("st_led0_j21", 1); at(21); check_v(8'(led[0]));
      expect_v("st_led3_j21", 1); check_v(8'(led[3]));
      expect_v("st_led3_j30", 1); at(30); check_v(8'(led[3]));
      expect_v("st_led3_j31", 0); at(31); check_v(8'(led[3]));

      // reset mid-blink, then restart as from power-up
      at(35);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      jc = 0;
      expect_v("mr_led_k0", 0);
      expect_v("mr_tick_k0", 0);
      check_v(8'(led));
      check_v(8'(tick));
      expect_v("mr_tick_k9", 0);  at(9);  check_v(8'(tick));
      expect_v("mr_tick_k10", 1); at(10); check_v(8'(tick));
      expect_v("mr_led_k30", 0);  at(30); check_v(8'(led));
      expect_v("mr_led_k31", 8);  at(31); check_v(8'(led));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
